judge_combo: RTL and testbench

JUDGE_COMBO -- requirements
Module: judge_combo

---
 rtl/game_pkg.sv | 23 ++
 rtl/judge_lane.sv | 93 +++++++++
 rtl/judge_combo.sv | 82 ++++++++
 tb/tb_judge_combo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level types: global game states, per-lane judge states and combo width.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SONG_SELECT = 2'd1,
        GAME_PLAY   = 2'd2,
        GAME_OVER   = 2'd3
    } game_state_t;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_OPEN = 1'b1
    } lane_state_t;

    localparam int COMBO_W = 8;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] v);
        return (v == COMBO_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/judge_lane.sv
// One judgement lane: button synchronizer, press edge detect, hit-window FSM and counter.
// hit/miss are decision pulses for the current cycle; the parent registers them.
module judge_lane
    import game_pkg::*;
#(
    parameter logic [23:0] WINDOW      = 24'd5_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic play,
    input  logic note,
    input  logic btn,
    output logic hit,
    output logic miss
);

    logic [SYNC_STAGES:0]   sh;
    logic [SYNC_STAGES-1:0] vsh;
    logic                   armed;
    logic                   press_p0;
    lane_state_t            state, state_n;
    logic [23:0]            cnt, cnt_n;

    // vsh marks which sync taps hold real samples, so a button held through
    // reset must be seen low once before its next rise counts as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            vsh      <= '0;
            armed    <= 1'b0;
            press_p0 <= 1'b0;
            state    <= L_IDLE;
            cnt      <= '0;
        end else begin
            sh       <= {sh[SYNC_STAGES-1:0], btn};
            vsh      <= {vsh[SYNC_STAGES-2:0], 1'b1};
            armed    <= armed | (vsh[SYNC_STAGES-1] & ~sh[SYNC_STAGES-1]);
            press_p0 <= armed & sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];
            state    <= state_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        hit     = 1'b0;
        miss    = 1'b0;
        state_n = state;
        cnt_n   = cnt;
        if (!play) begin
            state_n = L_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                L_IDLE: begin
                    if (note) begin
                        if (press_p0) begin
                            hit = 1'b1;
                        end else begin
                            state_n = L_OPEN;
                            cnt_n   = WINDOW - 24'd1;
                        end
                    end
                end
                L_OPEN: begin
                    // A press always scores the pending note; a fresh note then reopens.
                    if (press_p0) begin
                        hit = 1'b1;
                        if (note) begin
                            cnt_n = WINDOW - 24'd1;
                        end else begin
                            state_n = L_IDLE;
                            cnt_n   = '0;
                        end
                    end else if (note) begin
                        miss  = 1'b1;
                        cnt_n = WINDOW - 24'd1;
                    end else if (cnt == '0) begin
                        miss    = 1'b1;
                        state_n = L_IDLE;
                    end else begin
                        cnt_n = cnt - 24'd1;
                    end
                end
                default: begin
                    state_n = L_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/judge_combo.sv
// Two-lane hit judge with registered judge report and saturating combo counter.
// Optional JUDGE_MISS_COUNT_EN adds a saturating miss_count output.
module judge_combo
    import game_pkg::*;
#(
    parameter logic [23:0] WINDOW      = 24'd5_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         current_state,
    input  logic [1:0]         note_arrive,
    input  logic [1:0]         btn,
    output logic [1:0]         judge,
    output logic               judge_valid,
    output logic [COMBO_W-1:0] combo
`ifdef JUDGE_MISS_COUNT_EN
    ,
    output logic [COMBO_W-1:0] miss_count
`endif
);

    logic       in_play;
    logic       song_sel;
    logic [1:0] lane_hit;
    logic [1:0] lane_miss;
    logic       any_result;

    assign in_play    = (current_state == GAME_PLAY);
    assign song_sel   = (current_state == SONG_SELECT);
    assign any_result = |(lane_hit | lane_miss);

    judge_lane #(.WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)) u_lane0 (
        .clk   (clk),
        .rst_n (rst_n),
        .play  (in_play),
        .note  (note_arrive[0]),
        .btn   (btn[0]),
        .hit   (lane_hit[0]),
        .miss  (lane_miss[0])
    );

    judge_lane #(.WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)) u_lane1 (
        .clk   (clk),
        .rst_n (rst_n),
        .play  (in_play),
        .note  (note_arrive[1]),
        .btn   (btn[1]),
        .hit   (lane_hit[1]),
        .miss  (lane_miss[1])
    );

    // Report stage: a miss on either lane breaks the combo even if the other lane hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            judge       <= 2'b00;
            judge_valid <= 1'b0;
            combo       <= '0;
        end else begin
            judge       <= in_play ? lane_hit : 2'b00;
            judge_valid <= in_play & any_result;
            if (song_sel) begin
                combo <= '0;
            end else if (in_play && any_result) begin
                combo <= (|lane_miss) ? '0 : sat_inc(combo);
            end
        end
    end

`ifdef JUDGE_MISS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (song_sel) begin
            miss_count <= '0;
        end else if (in_play && (|lane_miss)) begin
            miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_judge_combo.sv
// Directed bench for judge_combo with WINDOW=8, SYNC_STAGES=2.
module tb_judge_combo;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] current_state;
    logic [1:0] note_arrive;
    logic [1:0] btn;
    logic [1:0] judge;
    logic       judge_valid;
    logic [7:0] combo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    judge_combo #(.WINDOW(24'd8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_state (current_state),
        .note_arrive   (note_arrive),
        .btn           (btn),
        .judge         (judge),
        .judge_valid   (judge_valid),
        .combo         (combo)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Notes driven at step 0; btn[k] rises after step pk (0 = with the note, -1 = never);
    // the note is re-driven after step renote. Observes n steps after the note.
    task automatic run_win(input logic [1:0] note, input int p0, input int p1, input int renote,
                           input int n, output int nv, output int first, output int last,
                           output logic [1:0] fj);
        nv = 0; first = -1; last = -1; fj = 2'b00;
        note_arrive = note;
        if (p0 == 0) btn[0] = 1'b1;
        if (p1 == 0) btn[1] = 1'b1;
        for (int i = 1; i <= n; i++) begin
            step();
            note_arrive = (i == renote) ? note : 2'b00;
            if (judge_valid) begin
                if (nv == 0) begin first = i; fj = judge; end
                last = i;
                nv++;
            end
            if (i == p0) btn[0] = 1'b1;
            if (i == p1) btn[1] = 1'b1;
        end
        btn = 2'b00;
        repeat (5) step();
    endtask

    task automatic quick_hit(input logic [1:0] m);
        int a, b, c;
        logic [1:0] d;
        run_win(m, m[0] ? 0 : -1, m[1] ? 0 : -1, -1, 6, a, b, c, d);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; current_state = GAME_PLAY; note_arrive = 2'b00; btn = 2'b00;
        repeat (3) step();
        checks++; if (judge !== 2'b00) begin errors++; $display("FAIL reset_judge: got %b expected 00", judge); end
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", judge_valid); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo: got %0d expected 0", combo); end
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_hit;
        int nv, first, last; logic [1:0] fj;
        run_win(2'b01, 3, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1) begin errors++; $display("FAIL hit_count: got %0d expected 1", nv); end
        checks++; if (first !== 7) begin errors++; $display("FAIL hit_latency: got %0d expected 7", first); end
        checks++; if (fj !== 2'b01) begin errors++; $display("FAIL hit_judge: got %b expected 01", fj); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL hit_combo: got %0d expected 1", combo); end
    endtask

    task automatic test_two_lane_hit;
        int nv, first, last; logic [1:0] fj;
        run_win(2'b11, 0, 0, -1, 10, nv, first, last, fj);
        checks++; if (first !== 4 || nv !== 1) begin errors++; $display("FAIL dual_timing: got first %0d count %0d expected 4 and 1", first, nv); end
        checks++; if (fj !== 2'b11) begin errors++; $display("FAIL dual_judge: got %b expected 11", fj); end
        checks++; if (combo !== 8'd2) begin errors++; $display("FAIL dual_combo: got %0d expected 2", combo); end
    endtask

    task automatic test_same_cycle_note;
        int nv, first, last; logic [1:0] fj;
        btn[0] = 1'b1;
        repeat (3) step();
        run_win(2'b01, -1, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 1) begin errors++; $display("FAIL same_cycle_timing: got count %0d first %0d expected 1 and 1", nv, first); end
        checks++; if (fj !== 2'b01) begin errors++; $display("FAIL same_cycle_judge: got %b expected 01", fj); end
        checks++; if (combo !== 8'd3) begin errors++; $display("FAIL same_cycle_combo: got %0d expected 3", combo); end
    endtask

    task automatic test_last_cycle_press;
        int nv, first, last; logic [1:0] fj;
        run_win(2'b01, 5, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 9) begin errors++; $display("FAIL last_cycle_timing: got count %0d first %0d expected 1 and 9", nv, first); end
        checks++; if (fj !== 2'b01) begin errors++; $display("FAIL last_cycle_judge: got %b expected 01", fj); end
        checks++; if (combo !== 8'd4) begin errors++; $display("FAIL last_cycle_combo: got %0d expected 4", combo); end
    endtask

    task automatic test_late_press;
        int nv, first, last; logic [1:0] fj;
        run_win(2'b01, 6, -1, -1, 16, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 9) begin errors++; $display("FAIL late_timing: got count %0d first %0d expected 1 and 9", nv, first); end
        checks++; if (fj !== 2'b00) begin errors++; $display("FAIL late_judge: got %b expected 00", fj); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL late_combo: got %0d expected 0", combo); end
    endtask

    task automatic test_miss;
        int nv, first, last; logic [1:0] fj;
        repeat (5) quick_hit(2'b01);
        checks++; if (combo !== 8'd5) begin errors++; $display("FAIL miss_precombo: got %0d expected 5", combo); end
        run_win(2'b01, -1, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 9) begin errors++; $display("FAIL miss_timing: got count %0d first %0d expected 1 and 9", nv, first); end
        checks++; if (fj !== 2'b00) begin errors++; $display("FAIL miss_judge: got %b expected 00", fj); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL miss_combo: got %0d expected 0", combo); end
    endtask

    task automatic test_reopen;
        int nv, first, last; logic [1:0] fj;
        quick_hit(2'b10);
        run_win(2'b10, -1, -1, 3, 16, nv, first, last, fj);
        checks++; if (nv !== 2) begin errors++; $display("FAIL reopen_count: got %0d expected 2", nv); end
        checks++; if (first !== 4 || last !== 12) begin errors++; $display("FAIL reopen_timing: got %0d,%0d expected 4,12", first, last); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reopen_combo: got %0d expected 0", combo); end
    endtask

    task automatic test_split;
        int nv, first, last; logic [1:0] fj;
        quick_hit(2'b01);
        run_win(2'b11, 5, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 9) begin errors++; $display("FAIL split_timing: got count %0d first %0d expected 1 and 9", nv, first); end
        checks++; if (fj !== 2'b01) begin errors++; $display("FAIL split_judge: got %b expected 01", fj); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL split_combo: got %0d expected 0", combo); end
    endtask

    task automatic test_ignored;
        int nv, first, last; logic [1:0] fj;
        quick_hit(2'b01);
        run_win(2'b00, 1, 1, -1, 12, nv, first, last, fj);
        checks++; if (nv !== 0) begin errors++; $display("FAIL idle_press_valid: got %0d expected 0", nv); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL idle_press_combo: got %0d expected 1", combo); end
        current_state = GAME_OVER;
        run_win(2'b11, 0, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 0) begin errors++; $display("FAIL gameover_valid: got %0d expected 0", nv); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL gameover_combo: got %0d expected 1", combo); end
        current_state = GAME_PLAY;
        note_arrive = 2'b01; step(); note_arrive = 2'b00; step();
        current_state = IDLE; step();
        current_state = GAME_PLAY;
        run_win(2'b00, -1, -1, -1, 12, nv, first, last, fj);
        checks++; if (nv !== 0) begin errors++; $display("FAIL abort_valid: got %0d expected 0", nv); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL abort_combo: got %0d expected 1", combo); end
    endtask

    task automatic test_saturate;
        int nv, first, last; logic [1:0] fj;
        for (int k = 0; k < 300 && combo !== 8'd255; k++) quick_hit(2'b01);
        checks++; if (combo !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", combo); end
        quick_hit(2'b11);
        run_win(2'b01, 0, -1, -1, 6, nv, first, last, fj);
        checks++; if (nv !== 1 || fj !== 2'b01) begin errors++; $display("FAIL sat_hit: got count %0d judge %b expected 1 and 01", nv, fj); end
        checks++; if (combo !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", combo); end
        current_state = SONG_SELECT;
        step();
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL songsel_clear: got %0d expected 0", combo); end
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL songsel_valid: got %b expected 0", judge_valid); end
        current_state = GAME_PLAY;
        step();
    endtask

    task automatic test_reset_mid;
        int nv, first, last; logic [1:0] fj;
        repeat (7) quick_hit(2'b01);
        checks++; if (combo !== 8'd7) begin errors++; $display("FAIL rstmid_precombo: got %0d expected 7", combo); end
        note_arrive = 2'b01; step(); note_arrive = 2'b00; step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL rstmid_combo: got %0d expected 0", combo); end
        step();
        rst_n = 1'b1;
        run_win(2'b00, -1, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 0) begin errors++; $display("FAIL rstmid_valid: got %0d expected 0", nv); end
    endtask

    task automatic test_release_btn_held;
        int nv, first, last; logic [1:0] fj;
        rst_n = 1'b0; btn = 2'b01;
        step();
        rst_n = 1'b1;
        run_win(2'b01, -1, -1, -1, 14, nv, first, last, fj);
        checks++; if (nv !== 1 || first !== 9) begin errors++; $display("FAIL held_timing: got count %0d first %0d expected 1 and 9", nv, first); end
        checks++; if (fj !== 2'b00) begin errors++; $display("FAIL held_judge: got %b expected 00", fj); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_two_lane_hit();
        test_same_cycle_note();
        test_last_cycle_press();
        test_late_press();
        test_miss();
        test_reopen();
        test_split();
        test_ignored();
        test_saturate();
        test_reset_mid();
        test_release_btn_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
